// File: rtl/uart_link_mux.sv
// Per-channel UART routing between internal controllers and external pins.
// Idle-gated mode switching, activity LED stretching and RX break detection.
module uart_link_mux #(
    parameter int unsigned NCH          = 2,
    parameter int unsigned IDLE_CYCLES  = 1024,
    parameter int unsigned LED_STRETCH  = 2**20,
    parameter int unsigned BREAK_CYCLES = 4096,
    parameter int unsigned MODE_RESET   = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [2*NCH-1:0]   mode_req,
    output logic [2*NCH-1:0]   mode_cur,
    input  logic [NCH-1:0]     int_txd,
    output logic [NCH-1:0]     int_rxd,
    input  logic [NCH-1:0]     ext_rxd,
    output logic [NCH-1:0]     ext_txd,
    output logic [NCH-1:0]     act_led,
    input  logic [NCH-1:0]     brk_clr,
    output logic [NCH-1:0]     brk_det
);

    localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int unsigned LED_W  = $clog2(LED_STRETCH + 1);
    localparam int unsigned BRK_W  = $clog2(BREAK_CYCLES + 1);

    localparam logic [1:0] MODE_EXT   = 2'd0;
    localparam logic [1:0] MODE_LOOP  = 2'd1;
    localparam logic [1:0] MODE_XCONN = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    typedef enum logic {
        ST_APPLIED = 1'b0,
        ST_PENDING = 1'b1
    } mode_state_e;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        localparam int unsigned PARTNER = i ^ 1;

        logic              partner_txd;
        logic              rx_meta_q, rxs_q;
        logic [1:0]        req;
        logic              src_sel;
        logic              line_idle;

        mode_state_e       state_q, state_d;
        logic [1:0]        mode_q, mode_d;
        logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

        logic              rxd_q, txd_q;
        logic              prev_txd_q, prev_src_q;
        logic [LED_W-1:0]  led_cnt_q, led_cnt_d;
        logic              led_q;
        logic [BRK_W-1:0]  brk_cnt_q, brk_cnt_d;
        logic              brk_q, brk_d;
        logic              fall;

        // Odd channel count: the unpaired last channel cross-connects to itself
        if (PARTNER < NCH) begin : g_pair
            assign partner_txd = int_txd[PARTNER];
        end else begin : g_solo
            assign partner_txd = int_txd[i];
        end

        assign req = mode_req[2*i +: 2];

        // Two-flop synchroniser for the asynchronous RX pin
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                rx_meta_q <= 1'b1;
                rxs_q     <= 1'b1;
            end else begin
                rx_meta_q <= ext_rxd[i];
                rxs_q     <= rx_meta_q;
            end
        end

        always_comb begin
            src_sel = rxs_q;
            case (mode_q)
                MODE_EXT:   src_sel = rxs_q;
                MODE_LOOP:  src_sel = int_txd[i];
                MODE_XCONN: src_sel = partner_txd;
                default:    src_sel = rxs_q;
            endcase
        end

        assign line_idle = int_txd[i] & src_sel;

        // Mode FSM: switch only after the lines have been idle long enough
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                state_q    <= ST_APPLIED;
                mode_q     <= 2'(MODE_RESET);
                idle_cnt_q <= '0;
            end else begin
                state_q    <= state_d;
                mode_q     <= mode_d;
                idle_cnt_q <= idle_cnt_d;
            end
        end

        always_comb begin
            state_d    = state_q;
            mode_d     = mode_q;
            idle_cnt_d = '0;
            case (state_q)
                ST_APPLIED: begin
                    if (req != mode_q && req != MODE_RSVD) state_d = ST_PENDING;
                end
                ST_PENDING: begin
                    if (req == mode_q || req == MODE_RSVD) begin
                        state_d = ST_APPLIED;
                    end else if (line_idle) begin
                        if (idle_cnt_q >= IDLE_W'(IDLE_CYCLES - 1)) begin
                            state_d = ST_APPLIED;
                            mode_d  = req;
                        end else begin
                            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                        end
                    end
                end
                default: state_d = ST_APPLIED;
            endcase
        end

        // LED stretch and break detection next-state
        always_comb begin
            fall      = (prev_txd_q & ~int_txd[i]) | (prev_src_q & ~src_sel);
            led_cnt_d = led_cnt_q;
            brk_cnt_d = '0;
            brk_d     = brk_q;
            if (fall) begin
                led_cnt_d = LED_W'(LED_STRETCH);
            end else if (led_cnt_q != '0) begin
                led_cnt_d = led_cnt_q - LED_W'(1);
            end
            if (!rxs_q) begin
                brk_cnt_d = (brk_cnt_q == BRK_W'(BREAK_CYCLES)) ? brk_cnt_q
                                                               : brk_cnt_q + BRK_W'(1);
            end
            if (brk_clr[i]) brk_d = 1'b0;
            if (!rxs_q && brk_cnt_d == BRK_W'(BREAK_CYCLES)) brk_d = 1'b1;
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                rxd_q      <= 1'b1;
                txd_q      <= 1'b1;
                prev_txd_q <= 1'b1;
                prev_src_q <= 1'b1;
                led_cnt_q  <= '0;
                led_q      <= 1'b0;
                brk_cnt_q  <= '0;
                brk_q      <= 1'b0;
            end else begin
                rxd_q      <= src_sel;
                txd_q      <= (mode_q == MODE_EXT) ? int_txd[i] : 1'b1;
                prev_txd_q <= int_txd[i];
                prev_src_q <= src_sel;
                led_cnt_q  <= led_cnt_d;
                led_q      <= (led_cnt_q != '0);
                brk_cnt_q  <= brk_cnt_d;
                brk_q      <= brk_d;
            end
        end

        assign mode_cur[2*i +: 2] = mode_q;
        assign int_rxd[i]         = rxd_q;
        assign ext_txd[i]         = txd_q;
        assign act_led[i]         = led_q;
        assign brk_det[i]         = brk_q;
    end

endmodule

// File: tb/tb_uart_link_mux.sv
// Directed bench for uart_link_mux: routing, idle-gated mode apply, LED stretch, break.
module tb_uart_link_mux;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] mode_req;
    logic [3:0] mode_cur;
    logic [1:0] int_txd, int_rxd, ext_rxd, ext_txd, act_led, brk_clr, brk_det;

    logic [5:0] o_mode_cur;
    logic [2:0] o_int_txd, o_int_rxd, o_ext_txd, o_act_led, o_brk_det;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_link_mux #(
        .NCH(2), .IDLE_CYCLES(8), .LED_STRETCH(16), .BREAK_CYCLES(32), .MODE_RESET(1)
    ) u_dut (
        .clk(clk), .resetn(resetn), .mode_req(mode_req), .mode_cur(mode_cur),
        .int_txd(int_txd), .int_rxd(int_rxd), .ext_rxd(ext_rxd), .ext_txd(ext_txd),
        .act_led(act_led), .brk_clr(brk_clr), .brk_det(brk_det)
    );

    uart_link_mux #(
        .NCH(3), .IDLE_CYCLES(4), .LED_STRETCH(4), .BREAK_CYCLES(4), .MODE_RESET(2)
    ) u_odd (
        .clk(clk), .resetn(resetn), .mode_req(6'b101010), .mode_cur(o_mode_cur),
        .int_txd(o_int_txd), .int_rxd(o_int_rxd), .ext_rxd(3'b111), .ext_txd(o_ext_txd),
        .act_led(o_act_led), .brk_clr(3'b000), .brk_det(o_brk_det)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        logic [7:0] pat;
        int         hi;
        pat       = 8'h55;
        resetn    = 1'b0;
        mode_req  = 4'b0101;
        int_txd   = 2'b11;
        ext_rxd   = 2'b11;
        brk_clr   = 2'b00;
        o_int_txd = 3'b111;
        tick(2);
        check("rst_mode_cur", 32'(mode_cur), 32'h5);
        check("rst_int_rxd", 32'(int_rxd), 32'h3);
        check("rst_ext_txd", 32'(ext_txd), 32'h3);
        check("rst_act_led", 32'(act_led), 32'h0);
        check("rst_brk_det", 32'(brk_det), 32'h0);
        check("rst_odd_mode", 32'(o_mode_cur), 32'h2a);
        resetn = 1'b1;
        tick(2);

        // Loopback from reset mode
        int_txd = 2'b10;
        tick(1);
        check("loop_rxd_low", 32'(int_rxd), 32'h2);
        check("loop_ext_txd", 32'(ext_txd), 32'h3);
        int_txd = 2'b11;
        tick(1);
        check("loop_rxd_high", 32'(int_rxd), 32'h3);

        // Odd channel count: last channel loops itself while reading XCONN
        o_int_txd = 3'b011;
        tick(1);
        check("odd_rxd_a", 32'(o_int_rxd), 32'h3);
        o_int_txd = 3'b110;
        tick(1);
        check("odd_rxd_b", 32'(o_int_rxd), 32'h5);
        check("odd_ext_txd", 32'(o_ext_txd), 32'h7);
        o_int_txd = 3'b111;

        // Ch0 to EXT with idle lines
        mode_req = 4'b0100;
        tick(8);
        check("ext_not_yet", 32'(mode_cur), 32'h5);
        tick(1);
        check("ext_applied", 32'(mode_cur), 32'h4);
        ext_rxd = 2'b10;
        int_txd = 2'b10;
        tick(1);
        check("ext_txd_lat1", 32'(ext_txd), 32'h2);
        tick(1);
        check("ext_rxd_lat2", 32'(int_rxd), 32'h3);
        tick(1);
        check("ext_rxd_lat3", 32'(int_rxd), 32'h2);
        ext_rxd = 2'b11;
        int_txd = 2'b11;
        tick(3);
        check("ext_rxd_back", 32'(int_rxd), 32'h3);

        // Ch1 to EXT held off by traffic
        mode_req = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            int_txd[1] = 1'b0;
            tick(1);
            int_txd[1] = 1'b1;
            tick(4);
        end
        check("busy_hold", 32'(mode_cur), 32'h4);
        tick(3);
        check("busy_last_7", 32'(mode_cur), 32'h4);
        tick(1);
        check("busy_last_8", 32'(mode_cur), 32'h0);

        // Both channels to XCONN
        mode_req = 4'b1010;
        tick(8);
        check("xc_not_yet", 32'(mode_cur), 32'h0);
        tick(1);
        check("xc_applied", 32'(mode_cur), 32'ha);
        for (int b = 0; b < 8; b++) begin
            int_txd[1] = pat[b];
            tick(1);
            check($sformatf("xc_bit%0d", b), 32'(int_rxd), 32'({1'b1, pat[b]}));
        end
        check("xc_ext_txd", 32'(ext_txd), 32'h3);
        int_txd = 2'b10;
        tick(1);
        check("xc_rxd1", 32'(int_rxd), 32'h1);
        int_txd = 2'b11;

        // Cancelled request, then reserved request
        mode_req = 4'b1001;
        tick(3);
        mode_req = 4'b1010;
        tick(12);
        check("cancel_keep", 32'(mode_cur), 32'ha);
        mode_req = 4'b1111;
        tick(12);
        check("rsvd_ignored", 32'(mode_cur), 32'ha);

        // LED stretch and retrigger
        tick(20);
        check("led_idle", 32'(act_led), 32'h0);
        int_txd[0] = 1'b0;
        tick(1);
        check("led_not_yet", 32'(act_led), 32'h0);
        int_txd[0] = 1'b1;
        tick(1);
        check("led_rise", 32'(act_led), 32'h3);
        tick(8);
        int_txd[0] = 1'b0;
        tick(1);
        int_txd[0] = 1'b1;
        tick(15);
        check("led_ext_15", 32'(act_led), 32'h3);
        tick(1);
        check("led_ext_16", 32'(act_led), 32'h3);
        tick(1);
        check("led_off", 32'(act_led), 32'h0);
        tick(20);
        int_txd[1] = 1'b0;
        tick(1);
        int_txd[1] = 1'b1;
        hi = 0;
        for (int k = 0; k < 25; k++) begin
            tick(1);
            if (act_led[0]) hi++;
        end
        check("led_width", 32'(hi), 32'd16);

        // Break on ch1
        ext_rxd = 2'b01;
        tick(33);
        check("brk_not_yet", 32'(brk_det), 32'h0);
        tick(1);
        check("brk_set", 32'(brk_det), 32'h2);
        tick(6);
        brk_clr = 2'b10;
        tick(1);
        brk_clr = 2'b00;
        check("brk_set_wins", 32'(brk_det), 32'h2);
        ext_rxd = 2'b11;
        tick(3);
        brk_clr = 2'b10;
        tick(1);
        brk_clr = 2'b00;
        check("brk_cleared", 32'(brk_det), 32'h0);

        // Reset during a pending change
        mode_req = 4'b0000;
        tick(3);
        resetn = 1'b0;
        #1;
        check("mid_rst_mode", 32'(mode_cur), 32'h5);
        check("mid_rst_ext_txd", 32'(ext_txd), 32'h3);
        mode_req = 4'b0101;
        tick(1);
        resetn = 1'b1;
        tick(12);
        check("mid_rst_discard", 32'(mode_cur), 32'h5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
